// File: rtl/reqack2rdyval.sv
// Receiving end of a four-phase req/ack link with bundled data, re-presented
// as a ready/valid stream through a one-entry registered output buffer.
module reqack2rdyval #(
    parameter int DWIDTH      = 1,
    parameter bit INCLUDE_CDC = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              ack,
    input  logic [DWIDTH-1:0] i_dat,
    output logic              vld,
    input  logic              rdy,
    output logic [DWIDTH-1:0] o_dat,
    output logic              o_dbg_state
);

    // Handshakes:
    //   req/ack  four-phase; i_dat must be stable from req rise until ack is seen high,
    //            and req may only fall once ack has been raised.
    //   vld/rdy  a word transfers on every rising edge where vld & rdy are both 1;
    //            vld never falls and o_dat never changes while vld=1 & rdy=0.

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_ack;
    logic              r_vld;
    logic [DWIDTH-1:0] r_dat;
    logic              w_req_i;
    logic              w_cap;

    generate
        if (INCLUDE_CDC) begin : g_cdc
            logic [1:0] r_sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= 2'b00;
                end else begin
                    r_sync <= {r_sync[0], req};
                end
            end
            assign w_req_i = r_sync[1];
        end else begin : g_no_cdc
            assign w_req_i = req;
        end
    endgenerate

    // A slot is free when empty or when the current word leaves this same edge.
    assign w_cap = (r_state == IDLE) && w_req_i && (!r_vld || rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cap) begin
                        r_state <= ACKED;
                        r_ack   <= 1'b1;
                    end
                end
                ACKED: begin
                    if (!w_req_i) begin
                        r_state <= IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase

            if (w_cap) begin
                r_vld <= 1'b1;
            end else if (rdy) begin
                r_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_dat <= i_dat;
        end
    end

    assign ack         = r_ack;
    assign vld         = r_vld;
    assign o_dat       = r_dat;
    assign o_dbg_state = (r_state == ACKED);

`ifndef SYNTHESIS
    // A request withdrawn before it was buffered would lose its data silently.
    logic r_req_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_d <= 1'b0;
        end else begin
            r_req_d <= w_req_i;
        end
    end

    a_req_held_until_capture: assert property (@(posedge clk) disable iff (!rst_n)
        !((r_state == IDLE) && r_req_d && !w_req_i));
`endif

endmodule

// File: tb/tb_reqack2rdyval.sv
// Bench for reqack2rdyval: vector table plus scoreboarded stream, CDC latency
// and mid-handshake reset sequences.
module tb_reqack2rdyval;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // same-clock instance
    logic         req = 1'b0;
    logic         ack;
    logic [W-1:0] dat = '0;
    logic         vld;
    logic         rdy = 1'b0;
    logic [W-1:0] odat;
    logic         dbg;

    // synchronizer instance
    logic         req_c = 1'b0;
    logic         ack_c;
    logic [W-1:0] dat_c = '0;
    logic         vld_c;
    logic         rdy_c = 1'b1;
    logic [W-1:0] odat_c;
    logic         dbg_c;

    reqack2rdyval #(.DWIDTH(W), .INCLUDE_CDC(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .i_dat(dat),
        .vld(vld), .rdy(rdy), .o_dat(odat), .o_dbg_state(dbg)
    );

    reqack2rdyval #(.DWIDTH(W), .INCLUDE_CDC(1'b1)) dut_cdc (
        .clk(clk), .rst_n(rst_n), .req(req_c), .ack(ack_c), .i_dat(dat_c),
        .vld(vld_c), .rdy(rdy_c), .o_dat(odat_c), .o_dbg_state(dbg_c)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int n_xfer   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic         mon_en = 1'b0;
    logic         prev_vld = 1'b0;
    logic         prev_rdy = 1'b0;
    logic [W-1:0] prev_dat = '0;

    // Samples just before each rising edge; a word moves on that edge when vld & rdy.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (prev_vld && !prev_rdy) begin
                    check("vld_hold", {31'd0, vld}, 32'd1);
                    check("dat_hold", {24'd0, odat}, {24'd0, prev_dat});
                end
                if (vld && rdy) begin
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        timeout("stream_spurious_word");
                    end else begin
                        check("stream_dat", {24'd0, odat}, {24'd0, exp_q.pop_front()});
                    end
                end
                prev_vld = vld;
                prev_rdy = rdy;
                prev_dat = odat;
            end else begin
                prev_vld = 1'b0;
                prev_rdy = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] d);
        int t;
        @(negedge clk);
        dat = d;
        req = 1'b1;
        exp_q.push_back(d);
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!ack && t < 300);
        if (!ack) timeout("send_ack_rise");
        @(negedge clk);
        req = 1'b0;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (ack && t < 20);
        if (ack) timeout("send_ack_fall");
    endtask

    task automatic cdc_xfer(input logic [W-1:0] d);
        @(posedge clk);
        #($urandom_range(2, 8));
        req_c = 1'b1;
        dat_c = d;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            if (e < 3) begin
                check($sformatf("cdc_vld_early_e%0d", e), {31'd0, vld_c}, 32'd0);
            end else begin
                check("cdc_vld_rise", {31'd0, vld_c}, 32'd1);
                check("cdc_ack_rise", {31'd0, ack_c}, 32'd1);
                check("cdc_dat", {24'd0, odat_c}, {24'd0, d});
            end
        end
        repeat (2) @(posedge clk);
        #($urandom_range(2, 8));
        req_c = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            if (e < 3) begin
                check($sformatf("cdc_ack_held_e%0d", e), {31'd0, ack_c}, 32'd1);
            end else begin
                check("cdc_ack_fall", {31'd0, ack_c}, 32'd0);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         req;
        logic [W-1:0] dat;
        logic         rdy;
        logic         e_ack;
        logic         e_vld;
        logic         chk_dat;
        logic [W-1:0] e_dat;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic r, input logic [W-1:0] d, input logic y,
                                input logic ea, input logic ev, input logic cd,
                                input logic [W-1:0] ed);
        vec_t v;
        v.req = r; v.dat = d; v.rdy = y;
        v.e_ack = ea; v.e_vld = ev; v.chk_dat = cd; v.e_dat = ed;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        // single transfer with rdy held high
        vecs[0]  = mk(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5);
        vecs[1]  = mk(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        vecs[2]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        vecs[3]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // back-pressure: second word waits ten cycles, then zero-bubble refill
        vecs[4]  = mk(1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11);
        vecs[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
        for (int i = 6; i < 16; i++) begin
            vecs[i] = mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
        end
        vecs[16] = mk(1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22);
        vecs[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22);
        vecs[18] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_vld", {31'd0, vld}, 32'd0);
        check("rst_state", {31'd0, dbg}, 32'd0);
        check("rst_cdc_ack", {31'd0, ack_c}, 32'd0);
        check("rst_cdc_vld", {31'd0, vld_c}, 32'd0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            req = vecs[i].req;
            dat = vecs[i].dat;
            rdy = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ack", i), {31'd0, ack}, {31'd0, vecs[i].e_ack});
            check($sformatf("vec%0d_state", i), {31'd0, dbg}, {31'd0, vecs[i].e_ack});
            check($sformatf("vec%0d_vld", i), {31'd0, vld}, {31'd0, vecs[i].e_vld});
            if (vecs[i].chk_dat) begin
                check($sformatf("vec%0d_dat", i), {24'd0, odat}, {24'd0, vecs[i].e_dat});
            end
        end

        // stream of 16 incrementing words against random rdy
        mon_en = 1'b1;
        n_xfer = 0;
        begin
            logic done;
            done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 16; i++) begin
                        send(8'h30 + 8'(i));
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(negedge clk);
                        rdy = 1'($urandom_range(0, 1));
                    end
                end
            join
        end
        @(negedge clk);
        rdy = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            #3;
            t++;
        end
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        check("stream_drained", exp_q.size(), 32'd0);
        check("stream_count", n_xfer, 32'd16);

        // synchronizer latency with asynchronous req edges
        cdc_xfer(8'hC3);
        cdc_xfer(8'h3C);
        cdc_xfer(8'h96);

        // reset while ACKED with a full buffer, req still high afterwards
        @(negedge clk);
        rdy = 1'b0;
        req = 1'b1;
        dat = 8'h5A;
        @(posedge clk);
        #1;
        check("pre_rst_ack", {31'd0, ack}, 32'd1);
        check("pre_rst_vld", {31'd0, vld}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ack", {31'd0, ack}, 32'd0);
        check("async_rst_vld", {31'd0, vld}, 32'd0);
        check("async_rst_state", {31'd0, dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ack", {31'd0, ack}, 32'd1);
        check("post_rst_vld", {31'd0, vld}, 32'd1);
        check("post_rst_dat", {24'd0, odat}, 32'h5A);
        @(negedge clk);
        req = 1'b0;
        rdy = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ack_fall", {31'd0, ack}, 32'd0);
        check("post_rst_vld_fall", {31'd0, vld}, 32'd0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reqack2rdyval.md
# reqack2rdyval

Converts an incoming four-phase Request–Acknowledge handshake, with bundled data, into an outgoing Ready–Valid handshake. It is the receiving end of a four-phase link, typically across a clock domain boundary. It captures the bundled data into a one-entry output buffer and acknowledges the sender as soon as the data is buffered. Optional CDC synchronization is built in on the Request line and is disabled by default.

## Interface
- DWIDTH, 1: data path bit width.
- INCLUDE_CDC, 1'b0: when set, a 2-flop synchronizer is instantiated on `req`.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- req  input  1  four-phase Request from the sender. It may be asynchronous to `clk` when INCLUDE_CDC=1.
- ack  output  1  four-phase Acknowledge to the sender. Registered.
- i_dat  input  DWIDTH  bundled data. The sender holds it stable from `req` rise until `ack` is seen high.
- vld  output  1  Valid of the output interface. Registered.
- rdy  input  1  Ready from the downstream consumer.
- o_dat  output  DWIDTH  output data. Registered and not reset.

## Operation
- `req_i` is the internal Request.
  - INCLUDE_CDC=0: `req_i` = `req`.
  - INCLUDE_CDC=1: `req_i` is the output of a 2-flop shift synchronizer, reset to 0.
- Input-side FSM has two states:
  - IDLE: `ack`=0.
  - ACKED: `ack`=1.
- Capture condition: `cap` = IDLE & `req_i` & (~`vld` | `rdy`).
- On `cap`:
  - `o_dat` <= `i_dat`.
  - `vld` <= 1.
  - `ack` <= 1.
  - FSM -> ACKED.
- In IDLE with `req_i`=1 while the buffer is full and not draining (`vld`=1, `rdy`=0): hold. No capture, `ack` stays 0.
- ACKED & ~`req_i`: `ack` <= 0, FSM -> IDLE.
- ACKED & `req_i`: hold.
- Output buffer:
  - `vld` & `rdy` without `cap`: `vld` <= 0.
  - `vld` & `rdy` with `cap` in the same cycle: `vld` stays 1 and `o_dat` takes the new data. Zero-bubble refill.
- `vld` never falls without `rdy`. `o_dat` is stable while `vld`=1 & `rdy`=0.
- Downstream may hold `rdy` low indefinitely. The sender is then back-pressured because `ack` is withheld.
- Reset, at any time including mid-handshake:
  - `ack`=0, `vld`=0, FSM=IDLE, synchronizer=0.
  - `o_dat` is unspecified until the first capture.
  - If `req` is still high after reset release, it is treated as a new request and captured.
- Assertion (simulation only): in IDLE, `req_i` must not fall before being captured. This needs one `req_d` delay flop used only by the assertion.

## Timing
- Edges are numbered relative to the first rising edge at which `req_i` is sampled high (edge 0), with the buffer free.
- Edge 0: capture. From edge 0, `vld`=1, `ack`=1, `o_dat`=data.
- Request-to-valid latency:
  - 1 cycle after `req_i`.
  - With INCLUDE_CDC=1, add 2 cycles from `req`.
- `ack` fall: at the first edge sampling `req_i`=0 in ACKED. This is 1 cycle after `req_i` falls.
- Earliest next capture: the edge after `ack` falls and `req_i` is high again.
- A full four-phase cycle is at least 4 `clk` cycles (no CDC) when paired with a same-clock sender. The CDC option adds sender/receiver synchronizer delays.
- `vld` accept: the transfer completes at the edge where `vld`=1 & `rdy`=1.
- No combinational path from `req` to any output. `rdy` feeds only flop inputs (`cap`, `vld`), not outputs.

## Test plan
- Single transfer, INCLUDE_CDC=0, `rdy`=1, `req` rises with `i_dat`=8'hA5.
  - Edge 0: `vld`=1, `o_dat`=8'hA5, `ack`=1.
  - Edge 1: `vld`=0.
  - Sender drops `req`; `ack`=0 one cycle later.
- Back-pressure, `rdy`=0, first request 8'h11 captured.
  - Second `req` with 8'h22 is held: `ack` stays 0 and `o_dat` stays 8'h11 for 10 cycles.
  - Pulse `rdy`: 8'h11 transfers, 8'h22 is captured in the same edge, and `vld` stays 1.
- Stream of 16 incrementing words with random `rdy`.
  - Output sequence is identical, with no loss or duplication.
  - `vld` never drops without `rdy`.
- INCLUDE_CDC=1, `req` toggled asynchronously relative to `clk`.
  - `vld` rises exactly 3 edges after `req` is first sampled.
  - `ack` falls 3 edges after `req` is first sampled low.
- Reset asserted while in ACKED with `vld`=1.
  - `ack`=0 and `vld`=0 immediately, without waiting for an edge.
  - After release, with `req` still high: capture on the first edge.
- Protocol assertion: drop `req` in IDLE before capture (blocked buffer) -> the assertion fires.
